// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: one-outstanding-operation controller for a registered ALU.
// Commands come in on a valid/ready stream. Operands and opcode are registered
// onto the ALU inputs. After LATENCY+1 clocks the ALU result and status are
// captured and returned, together with the command tag, on a valid/ready
// response stream.
//
// Handshake rule for both streams: a transfer happens on a rising edge where
// valid and ready are both high. A producer holding valid keeps its payload
// stable and does not drop valid until that edge. Here o_cmd_ready depends
// only on state, never on i_cmd_valid. o_rsp_valid and o_rsp_* depend only on
// registers, never on i_rsp_ready.
module alu_op_sequencer #(
  parameter int BITS     = 8,
  parameter int LATENCY  = 1,
  parameter int TAG_BITS = 4,
  parameter int CNT_BITS = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [BITS-1:0]     i_cmd_a,
  input  logic [BITS-1:0]     i_cmd_b,
  input  logic [1:0]          i_cmd_op,
  input  logic [TAG_BITS-1:0] i_cmd_tag,
  output logic [BITS-1:0]     o_alu_a,
  output logic [BITS-1:0]     o_alu_b,
  output logic [1:0]          o_alu_op,
  input  logic [BITS-1:0]     i_alu_out,
  input  logic [3:0]          i_alu_status,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [BITS-1:0]     o_rsp_out,
  output logic [3:0]          o_rsp_status,
  output logic [1:0]          o_rsp_op,
  output logic [TAG_BITS-1:0] o_rsp_tag,
  output logic                o_busy,
  output logic [CNT_BITS-1:0] o_op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // LATENCY is at most 15, so 4 bits cover every legal load value.
  localparam logic [3:0] LAT_LOAD = 4'(LATENCY);

  state_t                state_q,      state_d;
  logic [3:0]            wait_cnt_q,   wait_cnt_d;
  logic [BITS-1:0]       alu_a_q,      alu_a_d;
  logic [BITS-1:0]       alu_b_q,      alu_b_d;
  logic [1:0]            alu_op_q,     alu_op_d;
  logic [TAG_BITS-1:0]   tag_q,        tag_d;
  logic [BITS-1:0]       rsp_out_q,    rsp_out_d;
  logic [3:0]            rsp_status_q, rsp_status_d;
  logic [1:0]            rsp_op_q,     rsp_op_d;
  logic [TAG_BITS-1:0]   rsp_tag_q,    rsp_tag_d;
  logic [CNT_BITS-1:0]   op_count_q,   op_count_d;

  // Next-state and datapath: accept in IDLE, count down in WAIT, and hold the
  // response in RESP until it is taken.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    tag_d        = tag_q;
    rsp_out_d    = rsp_out_q;
    rsp_status_d = rsp_status_q;
    rsp_op_d     = rsp_op_q;
    rsp_tag_d    = rsp_tag_q;
    op_count_d   = op_count_q;
    unique case (state_q)
      IDLE: begin
        if (i_cmd_valid) begin
          alu_a_d    = i_cmd_a;
          alu_b_d    = i_cmd_b;
          alu_op_d   = i_cmd_op;
          tag_d      = i_cmd_tag;
          wait_cnt_d = LAT_LOAD;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          // The ALU output has had LATENCY edges to settle since the operands
          // changed, so this edge is the one where it is valid.
          rsp_out_d    = i_alu_out;
          rsp_status_d = i_alu_status;
          rsp_op_d     = alu_op_q;
          rsp_tag_d    = tag_q;
          state_d      = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (i_rsp_ready) begin
          // Returning to IDLE without accepting keeps one IDLE cycle between
          // operations.
          op_count_d = op_count_q + CNT_BITS'(1);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. Reset aborts any operation in flight.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      tag_q        <= '0;
      rsp_out_q    <= '0;
      rsp_status_q <= '0;
      rsp_op_q     <= '0;
      rsp_tag_q    <= '0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      tag_q        <= tag_d;
      rsp_out_q    <= rsp_out_d;
      rsp_status_q <= rsp_status_d;
      rsp_op_q     <= rsp_op_d;
      rsp_tag_q    <= rsp_tag_d;
      op_count_q   <= op_count_d;
    end
  end

  assign o_cmd_ready  = (state_q == IDLE);
  assign o_busy       = (state_q != IDLE);
  assign o_rsp_valid  = (state_q == RESP);
  assign o_alu_a      = alu_a_q;
  assign o_alu_b      = alu_b_q;
  assign o_alu_op     = alu_op_q;
  assign o_rsp_out    = rsp_out_q;
  assign o_rsp_status = rsp_status_q;
  assign o_rsp_op     = rsp_op_q;
  assign o_rsp_tag    = rsp_tag_q;
  assign o_op_count   = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer. Four instances run side by side with LATENCY
// 0, 1, 3 and 15. The LATENCY=1 instance keeps a 16-bit counter and the others
// use a 4-bit counter so that it wraps. Each instance has its own stub ALU,
// model, checker and driver. The stub presents the true result only in the
// single cycle before the expected capture edge and junk at all other times.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests    = 0;
  int fails    = 0;
  int done_cnt = 0;

  task automatic chk(input string nm, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s inst%0d got %0h want %0h", nm, inst, act, exp);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : inst
    localparam int LAT = (g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 3 : 15;
    localparam int CB  = (g == 1) ? 16 : 4;

    logic          rst_n = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          rsp_ready = 1'b0;
    logic [7:0]    cmd_a = '0, cmd_b = '0;
    logic [1:0]    cmd_op = '0;
    logic [3:0]    cmd_tag = '0;
    logic [7:0]    alu_out = '0;
    logic [3:0]    alu_status = '0;
    logic          cmd_ready, rsp_valid, busy;
    logic [7:0]    alu_a, alu_b, rsp_out;
    logic [1:0]    alu_op, rsp_op;
    logic [3:0]    rsp_status, rsp_tag;
    logic [CB-1:0] op_count;

    alu_op_sequencer #(.BITS(8), .LATENCY(LAT), .TAG_BITS(4), .CNT_BITS(CB)) dut (
      .i_clk(clk), .i_rst(rst_n),
      .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
      .i_cmd_a(cmd_a), .i_cmd_b(cmd_b), .i_cmd_op(cmd_op), .i_cmd_tag(cmd_tag),
      .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op),
      .i_alu_out(alu_out), .i_alu_status(alu_status),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
      .o_rsp_out(rsp_out), .o_rsp_status(rsp_status), .o_rsp_op(rsp_op),
      .o_rsp_tag(rsp_tag), .o_busy(busy), .o_op_count(op_count)
    );

    // Model: the cycle of acceptance, whether a response is outstanding, and
    // the responses owed in order. A response record is
    // {out[17:10], status[9:6], op[5:4], tag[3:0]}.
    int          cyc = 0, t_acc = -100, acc_cnt = 0, cnt_m = 0;
    bit          in_flight = 1'b0, rsp_pending = 1'b0, chk_en = 1'b0;
    logic [17:0] exp_alu = '0;
    logic [17:0] last_rsp = '0;
    logic [17:0] exp_q[$];

    task automatic model_reset();
      in_flight   = 1'b0;
      rsp_pending = 1'b0;
      cnt_m       = 0;
      t_acc       = -100;
      exp_alu     = '0;
      last_rsp    = '0;
      exp_q.delete();
    endtask

    // Model update on each rising edge, using inputs driven 2 ns after the
    // previous edge.
    always @(posedge clk) begin
      bit rdy;
      cyc++;
      if (rst_n) begin
        rdy = !in_flight;
        if (rsp_pending && rsp_ready) begin
          rsp_pending = 1'b0;
          in_flight   = 1'b0;
          cnt_m++;
          last_rsp    = exp_q.pop_front();
        end else if (in_flight && !rsp_pending && cyc == t_acc + LAT + 1) begin
          rsp_pending = 1'b1;
        end
        if (rdy && cmd_valid) begin
          in_flight = 1'b1;
          t_acc     = cyc;
          acc_cnt++;
          exp_alu   = {cmd_a, cmd_b, cmd_op};
          exp_q.push_back({cmd_a ^ cmd_b, cmd_op, 2'b01, cmd_op, cmd_tag});
        end
      end
    end

    // Stub ALU: the true value (a ^ b, {op, 01}) appears only in the cycle
    // before the expected capture edge. Every other cycle shows junk.
    always @(posedge clk) begin
      #1;
      if (cyc == t_acc + LAT) begin
        alu_out    = alu_a ^ alu_b;
        alu_status = {alu_op, 2'b01};
      end else begin
        alu_out    = (alu_a ^ alu_b) ^ 8'($urandom_range(1, 255));
        alu_status = {alu_op, 2'b01} ^ 4'($urandom_range(1, 15));
      end
    end

    // Compare every output against the model on every falling edge.
    always @(negedge clk) begin
      logic [17:0] er;
      if (chk_en) begin
        if (rsp_pending) er = exp_q[0];
        else             er = last_rsp;
        chk("cmd_ready",  g, 32'(cmd_ready),  32'(!in_flight));
        chk("busy",       g, 32'(busy),       32'(in_flight));
        chk("rsp_valid",  g, 32'(rsp_valid),  32'(rsp_pending));
        chk("alu_a",      g, 32'(alu_a),      32'(exp_alu[17:10]));
        chk("alu_b",      g, 32'(alu_b),      32'(exp_alu[9:2]));
        chk("alu_op",     g, 32'(alu_op),     32'(exp_alu[1:0]));
        chk("rsp_out",    g, 32'(rsp_out),    32'(er[17:10]));
        chk("rsp_status", g, 32'(rsp_status), 32'(er[9:6]));
        chk("rsp_op",     g, 32'(rsp_op),     32'(er[5:4]));
        chk("rsp_tag",    g, 32'(rsp_tag),    32'(er[3:0]));
        chk("op_count",   g, 32'(op_count),   32'(cnt_m % (1 << CB)));
      end
    end

    task automatic step();
      @(posedge clk);
      #2;
    endtask

    // Present a command and hold it until accepted.
    task automatic issue(input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] op, input logic [3:0] tag);
      int n0 = acc_cnt;
      int k  = 0;
      cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag; cmd_valid = 1'b1;
      while (acc_cnt == n0 && k < 100) begin
        step();
        k++;
      end
      if (acc_cnt == n0) chk("accept_timeout", g, 32'(k), 32'(0));
      cmd_valid = 1'b0;
    endtask

    // Count edges until o_rsp_valid is seen.
    task automatic wait_rsp(output int k);
      k = 0;
      while (!rsp_valid && k < 100) begin
        step();
        k++;
      end
      if (!rsp_valid) chk("rsp_timeout", g, 32'(k), 32'(0));
    endtask

    // Wait for the outstanding response to be handed off, optionally
    // randomising downstream ready.
    task automatic wait_done(input bit rnd);
      int n0 = cnt_m;
      int k  = 0;
      while (cnt_m == n0 && k < 300) begin
        if (rnd) rsp_ready = 1'($urandom_range(0, 1));
        step();
        k++;
      end
      if (cnt_m == n0) chk("done_timeout", g, 32'(k), 32'(0));
    endtask

    initial begin : drive
      int k;
      #1;
      rst_n = 1'b0;
      model_reset();
      chk_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_a     = 8'($urandom);
        cmd_b     = 8'($urandom);
        cmd_op    = 2'($urandom);
        cmd_tag   = 4'($urandom);
        rsp_ready = 1'($urandom_range(0, 1));
        step();
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      rst_n     = 1'b1;
      step();
      chk("idle_after_reset", g, 32'(busy), 32'(0));

      // Single directed operation.
      issue(8'h6F, 8'h18, 2'b00, 4'h3);
      chk("alu_a_issued", g, 32'(alu_a), 32'h6F);
      wait_rsp(k);
      chk("rsp_latency", g, 32'(k), 32'(LAT + 1));
      chk("first_out", g, 32'(rsp_out), 32'h77);
      chk("first_status", g, 32'(rsp_status), 32'h1);
      chk("first_tag", g, 32'(rsp_tag), 32'h3);
      step();
      chk("first_count", g, 32'(op_count), 32'd1);

      // Backpressure with a second command waiting throughout.
      rsp_ready = 1'b0;
      issue(8'h5A, 8'h3C, 2'b01, 4'h4);
      wait_rsp(k);
      cmd_a = 8'hAA; cmd_b = 8'h01; cmd_op = 2'b11; cmd_tag = 4'h5;
      cmd_valid = 1'b1;
      repeat (5) step();
      chk("bp_cmd_ready", g, 32'(cmd_ready), 32'd0);
      rsp_ready = 1'b1;
      step();
      chk("bp_idle_gap", g, 32'(cmd_ready), 32'd1);
      step();
      cmd_valid = 1'b0;
      wait_rsp(k);
      chk("second_out", g, 32'(rsp_out), 32'hAB);
      chk("second_status", g, 32'(rsp_status), 32'hD);
      step();

      // Random traffic with random downstream stalls.
      for (int i = 0; i < 40; i++) begin
        rsp_ready = 1'($urandom_range(0, 1));
        repeat ($urandom_range(0, 2)) step();
        issue(8'($urandom), 8'($urandom), 2'($urandom), 4'($urandom));
        wait_done(1'b1);
      end

      // Reset during WAIT aborts the operation.
      rsp_ready = 1'b1;
      issue(8'h12, 8'h34, 2'b10, 4'h9);
      rst_n = 1'b0;
      model_reset();
      step();
      chk("abort_rsp_valid", g, 32'(rsp_valid), 32'd0);
      chk("abort_count", g, 32'(op_count), 32'd0);
      chk("abort_alu_a", g, 32'(alu_a), 32'd0);
      rst_n = 1'b1;
      repeat (LAT + 4) step();

      // Seventeen back-to-back operations with tags 0..15, 0.
      for (int t = 0; t < 17; t++) begin
        issue(8'($urandom), 8'($urandom), 2'($urandom), 4'(t));
        wait_done(1'b0);
      end
      chk("wrap_count", g, 32'(op_count), 32'(17 % (1 << CB)));

      done_cnt++;
    end
  end

  initial begin
    for (int i = 0; i < 60000 && done_cnt < 4; i++) @(posedge clk);
    if (done_cnt < 4) chk("global_timeout", 0, 32'(done_cnt), 32'd4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Initiator-side controller for the registered ALU. It accepts operation commands over a valid/ready stream, drives the ALU operand and opcode inputs, and waits the ALU's fixed pipeline latency. It then captures the ALU result and status and returns them, with the command tag, on a valid/ready response stream. It replaces bench-style direct operand driving in integrated designs, with one outstanding operation at a time.

Parameters:
BITS, 8, operand/result width; must match the attached ALU.
LATENCY, 1, ALU register stages between operand change and valid o_out/o_status; legal range 0..15.
TAG_BITS, 4, width of the command tag echoed on the response.
CNT_BITS, 16, width of the completed-operation counter.

Ports:
i_clk  in  1  clock; all state on the rising edge.
i_rst  in  1  asynchronous active-low reset.
i_cmd_valid  in  1  command present.
o_cmd_ready  out  1  sequencer can accept a command.
i_cmd_a  in  BITS  operand A.
i_cmd_b  in  BITS  operand B.
i_cmd_op  in  2  00 subtract, 01 compare, 10 shift, 11 bit-change.
i_cmd_tag  in  TAG_BITS  opaque command identifier.
o_alu_a  out  BITS  to ALU i_a.
o_alu_b  out  BITS  to ALU i_b.
o_alu_op  out  2  to ALU i_op.
i_alu_out  in  BITS  from ALU o_out.
i_alu_status  in  4  from ALU o_status.
o_rsp_valid  out  1  response present.
i_rsp_ready  in  1  downstream accepts response.
o_rsp_out  out  BITS  captured ALU result.
o_rsp_status  out  4  captured ALU status.
o_rsp_op  out  2  opcode of the completed command.
o_rsp_tag  out  TAG_BITS  tag of the completed command.
o_busy  out  1  high in any state other than IDLE.
o_op_count  out  CNT_BITS  number of responses handed off.

Behaviour:
- Reset (i_rst low, asynchronous): state IDLE; every output is 0 except o_cmd_ready, which is 1. The latency counter is cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - o_cmd_ready = 1.
  - On i_cmd_valid & o_cmd_ready at edge E0: register a/b/op onto o_alu_a/b/op and latch the tag.
  - Load the wait counter with LATENCY and go to WAIT.
- WAIT:
  - o_cmd_ready = 0.
  - If counter == 0: sample i_alu_out/i_alu_status into o_rsp_out/o_rsp_status, set o_rsp_op/o_rsp_tag, and go to RESP. Otherwise decrement the counter.
  - Result: capture happens at edge E0+LATENCY+1. LATENCY=0 captures at E0+1, for use with a combinational ALU.
- RESP:
  - o_rsp_valid = 1, o_cmd_ready = 0.
  - All o_rsp_* are held stable until i_rsp_ready is high at an edge.
  - On that handshake: o_rsp_valid drops, o_op_count increments, and the state returns to IDLE.
- o_rsp_valid must never deassert without a handshake. Response fields are don't-care-free: they keep their last captured value after the handshake.
- o_alu_a/b/op hold the last issued command until the next acceptance. They are not cleared on completion.
- Throughput: one command per LATENCY+3 cycles when i_rsp_ready is held high.
- A command presented while busy is not accepted, because o_cmd_ready is low. The upstream holds it, and it is taken in the first IDLE cycle.
- The sequencer does not accept a new command in the same cycle as a response handshake. IDLE is always visited for at least one cycle.
- o_op_count wraps modulo 2^CNT_BITS with no saturation.
- Reset asserted in WAIT or RESP aborts the operation asynchronously. No response is produced, and the counter is cleared.
- All four opcodes are legal. The status is passed through verbatim; the sequencer does not interpret it.

Test Plan:
Benches use a stub ALU with configurable latency: out = a ^ b, status = {op, 2'b01}.
- Reset: hold i_rst=0 for 3 cycles with random inputs -> all outputs 0, o_cmd_ready=1; release -> still IDLE, o_busy=0.
- Single op, LATENCY=1:
  - Stimulus: cmd a=8'h6F, b=8'h18, op=00, tag=4'h3 accepted at E0, i_rsp_ready=1.
  - Expected: o_alu_a=8'h6F after E0; o_rsp_valid rises after E0+2 with out=8'h77, status=4'b0001, tag=3; o_op_count=1 after handshake.
- Backpressure:
  - Stimulus: i_rsp_ready=0 for 5 cycles during RESP, with a second command (a=8'hAA, b=8'h01, op=11) valid throughout.
  - Expected: response fields stable; o_cmd_ready=0. After ready rises, one IDLE cycle, then the second command is accepted and its response has out=8'hAB, status=4'b1101.
- LATENCY sweep:
  - Stimulus: LATENCY=0, 1, 3, 15.
  - Expected: capture exactly at E0+LATENCY+1. Stub output changed one cycle late must not be captured.
- Reset mid-op: pull i_rst low during WAIT -> o_rsp_valid never rises, o_op_count=0, o_alu_* = 0.
- Wrap: CNT_BITS=4, 17 back-to-back ops -> o_op_count reads 1. Tags 0..15 are returned in order.
